data_sync_multi: RTL and testbench
==================================

// Module: data_sync_multi
// PURPOSE
//  Parametrised multi-bit CDC synchroniser for the destination clock domain.
//  - Carries a source-domain data bus plus a qualifying enable into domain clk.
//  - Only the enable passes through an N-stage flop chain; the bus is captured once the synchronised enable is seen.
//  - Emits a one-cycle enable_pulse with each capture.
//  - Intended for the register-file, UART config and ALU-result crossings.
// PARAMETERS
//  NUM_STAGES  2      enable synchroniser depth; legal range 2..4
//  BUS_WIDTH   8      width of unsync_bus / sync_bus; >=1
//  RST_VAL     0      reset value of sync_bus (BUS_WIDTH bits)
// PORTS
//  clk          in   1          destination-domain clock
//  rst          in   1          reset; asynchronous, active-low
//  unsync_bus   in   BUS_WIDTH  source-domain data; must be stable while bus_enable is asserted
//  bus_enable   in   1          source-domain qualifier (level; toggle mode when macro set)
//  sync_bus     out  BUS_WIDTH  captured data, held between captures
//  enable_pulse out  1          one-cycle strobe; same cycle sync_bus is updated
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - sync chain[NUM_STAGES-1:0]=0, edge flop=0, enable_pulse=0, sync_bus=RST_VAL.
//    - Release is seen on the next posedge clk.
//  - Chain: chain[0]<=bus_enable; chain[i]<=chain[i-1]; s_en=chain[NUM_STAGES-1].
//  - Edge flop: en_q<=s_en every cycle.
//  - Detect (level mode): det = s_en & ~en_q.
//  - Outputs, registered on the same edge:
//    - enable_pulse<=det.
//    - sync_bus<= det ? unsync_bus : sync_bus.
//  - Latency: bus_enable 0->1 sampled at edge E0 gives enable_pulse=1 and new sync_bus after edge E0+NUM_STAGES.
//    - enable_pulse is high for exactly one cycle.
//  - Source protocol (caller's contract):
//    - bus_enable high >= NUM_STAGES+1 clk periods.
//    - bus_enable low >= NUM_STAGES+1 periods between transfers.
//    - unsync_bus stable from bus_enable rise to its fall.
//    - Violations may drop or merge transfers, but must never produce a pulse >1 cycle.
//  - bus_enable held high indefinitely: single pulse only; no re-capture.
//  - bus_enable falling edge: no pulse, sync_bus unchanged.
//  - Reset mid-transfer: transfer discarded, outputs return to reset values.
//    - If bus_enable is still high after release, it is treated as a new rise (pulse after NUM_STAGES+1 edges).
//  - No combinational path from any input to any output.
//  - NUM_STAGES outside 2..4: elaboration error ($error in generate).
// CONFIGURATION
//  - Macro DATA_SYNC_TOGGLE_EN:
//    - Defined: bus_enable is a toggle; det = s_en ^ en_q.
//    - Every transition (0->1 or 1->0) is one transfer with one pulse and one capture.
//    - Minimum spacing between toggles is NUM_STAGES+1 clk periods.
//  - Undefined (default): level mode as above; falling edges ignored.
// TESTING (NUM_STAGES=2, BUS_WIDTH=8, RST_VAL=0 unless noted)
//  - Reset:
//    - rst=0 with bus_enable=1, unsync_bus=8'hFF -> sync_bus=8'h00, enable_pulse=0 throughout.
//    - After release, pulse at edge 3 with sync_bus=8'hFF.
//  - Basic transfer:
//    - unsync_bus=8'hA5, bus_enable 0->1 at E0 -> enable_pulse=1 only in cycle after E0+2, sync_bus=8'hA5.
//    - Hold bus_enable 10 cycles -> no further pulse.
//  - Back-to-back: 8'h3C then 8'hC3, each enable high 3 / low 3 cycles -> exactly two pulses, sync_bus 8'h3C then 8'hC3.
//  - Data hold: change unsync_bus to 8'h11 after the pulse while enable is still high -> sync_bus stays 8'hA5.
//  - Mid-transfer reset: assert rst one cycle after bus_enable rise -> no pulse, sync_bus=0.
//    - After release with enable still high, one pulse.
//  - Toggle mode (DATA_SYNC_TOGGLE_EN, NUM_STAGES=3):
//    - Toggles 0->1->0 spaced 5 cycles -> two pulses, each 3 edges after its toggle.

Source files
------------

// File: rtl/data_sync_multi.sv
// Multi-bit CDC synchroniser: only bus_enable crosses through a NUM_STAGES flop chain; the bus is
// sampled once the synchronised enable edge is seen. Define DATA_SYNC_TOGGLE_EN for toggle-mode enable.
module data_sync_multi #(
    parameter int                   NUM_STAGES = 2,
    parameter int                   BUS_WIDTH  = 8,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse
);

    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("data_sync_multi: NUM_STAGES must be in 2..4");
        end
    endgenerate

    logic [NUM_STAGES-1:0] chain_q;
    logic [NUM_STAGES-1:0] chain_d;
    logic                  en_q;
    logic                  pulse_q;
    logic                  pulse_d;
    logic [BUS_WIDTH-1:0]  bus_q;
    logic [BUS_WIDTH-1:0]  bus_d;
    logic                  s_en;
    logic                  det;

    assign s_en = chain_q[NUM_STAGES-1];

`ifdef DATA_SYNC_TOGGLE_EN
    assign det = s_en ^ en_q;
`else
    assign det = s_en & ~en_q;
`endif

    always_comb begin
        chain_d = {chain_q[NUM_STAGES-2:0], bus_enable};
        pulse_d = det;
        bus_d   = bus_q;
        // unsync_bus has been stable for NUM_STAGES cycles by the time det fires
        if (det) begin
            bus_d = unsync_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
            en_q    <= 1'b0;
            pulse_q <= 1'b0;
            bus_q   <= RST_VAL;
        end else begin
            chain_q <= chain_d;
            en_q    <= s_en;
            pulse_q <= pulse_d;
            bus_q   <= bus_d;
        end
    end

    assign sync_bus     = bus_q;
    assign enable_pulse = pulse_q;

endmodule

// File: tb/tb_data_sync_multi.sv
// Self-checking bench for data_sync_multi: directed scenarios plus randomized transfers against a
// history-window reference model. Build with DATA_SYNC_TOGGLE_EN to exercise toggle mode (NUM_STAGES=3).
module tb_data_sync_multi;

`ifdef DATA_SYNC_TOGGLE_EN
    localparam int NS = 3;
`else
    localparam int NS = 2;
`endif
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] unsync_bus = '0;
    logic          bus_enable = 1'b0;
    logic [BW-1:0] sync_bus;
    logic          enable_pulse;

    int checks = 0;
    int fails  = 0;

    data_sync_multi #(
        .NUM_STAGES(NS),
        .BUS_WIDTH (BW),
        .RST_VAL   (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .unsync_bus  (unsync_bus),
        .bus_enable  (bus_enable),
        .sync_bus    (sync_bus),
        .enable_pulse(enable_pulse)
    );

    always #5 clk = ~clk;

    // Reference: en_h[k] is bus_enable as sampled k+1 edges ago. A transfer is reported
    // NUM_STAGES edges after the sampled edge of bus_enable, capturing the bus present then.
    logic [7:0]    en_h;
    logic          m_pulse;
    logic [BW-1:0] m_bus;
    logic          m_det;

`ifdef DATA_SYNC_TOGGLE_EN
    assign m_det = en_h[NS-1] != en_h[NS];
`else
    assign m_det = en_h[NS-1] && !en_h[NS];
`endif

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_h    <= '0;
            m_pulse <= 1'b0;
            m_bus   <= 8'h00;
        end else begin
            en_h    <= {en_h[6:0], bus_enable};
            m_pulse <= m_det;
            m_bus   <= m_det ? unsync_bus : m_bus;
        end
    end

    // Advance n cycles, sampling outputs at each negedge; reports pulse count, the cycle
    // index of the first pulse, sync_bus at each pulse, and the longest run of pulses.
    int            r_np;
    int            r_first;
    int            r_maxrun;
    logic [BW-1:0] r_bus[$];

    task automatic run(input int n);
        int cur;
        r_np = 0;
        r_first = -1;
        r_maxrun = 0;
        cur = 0;
        r_bus.delete();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (enable_pulse === 1'b1) begin
                r_np++;
                cur++;
                if (r_first < 0) r_first = i;
                r_bus.push_back(sync_bus);
            end else begin
                cur = 0;
            end
            if (cur > r_maxrun) r_maxrun = cur;
        end
    endtask

    task automatic test_reset();
        bus_enable = 1'b1;
        unsync_bus = 8'hFF;
        rst = 1'b0;
        run(4);
        checks++;
        if (r_np !== 0) begin
            fails++;
            $display("FAIL reset_pulse: got %0d pulses, expected 0", r_np);
        end
        checks++;
        if (sync_bus !== 8'h00) begin
            fails++;
            $display("FAIL reset_bus: got %h expected %h", sync_bus, 8'h00);
        end
        rst = 1'b1;
        run(NS + 4);
        checks++;
        if (r_np !== 1 || r_first !== NS + 1) begin
            fails++;
            $display("FAIL reset_release: got %0d pulses first at %0d, expected 1 at %0d", r_np, r_first, NS + 1);
        end
        checks++;
        if (sync_bus !== 8'hFF) begin
            fails++;
            $display("FAIL reset_release_bus: got %h expected %h", sync_bus, 8'hFF);
        end
        bus_enable = 1'b0;
        run(NS + 3);
    endtask

`ifndef DATA_SYNC_TOGGLE_EN
    task automatic test_basic();
        unsync_bus = 8'hA5;
        bus_enable = 1'b1;
        run(NS + 1 + 10);
        checks++;
        if (r_np !== 1 || r_first !== NS + 1) begin
            fails++;
            $display("FAIL basic_pulse: got %0d pulses first at %0d, expected 1 at %0d", r_np, r_first, NS + 1);
        end
        checks++;
        if (sync_bus !== 8'hA5) begin
            fails++;
            $display("FAIL basic_bus: got %h expected %h", sync_bus, 8'hA5);
        end
    endtask

    task automatic test_data_hold();
        unsync_bus = 8'h11;
        run(5);
        checks++;
        if (r_np !== 0 || sync_bus !== 8'hA5) begin
            fails++;
            $display("FAIL data_hold: got %0d pulses bus %h, expected 0 pulses bus %h", r_np, sync_bus, 8'hA5);
        end
        bus_enable = 1'b0;
        run(NS + 3);
        checks++;
        if (r_np !== 0 || sync_bus !== 8'h11 - 8'h11 + 8'hA5) begin
            fails++;
            $display("FAIL falling_edge: got %0d pulses bus %h, expected 0 pulses bus %h", r_np, sync_bus, 8'hA5);
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] seen[$];
        int total;
        logic [BW-1:0] vals[2];
        vals[0] = 8'h3C;
        vals[1] = 8'hC3;
        total = 0;
        for (int t = 0; t < 2; t++) begin
            unsync_bus = vals[t];
            bus_enable = 1'b1;
            run(NS + 1);
            total += r_np;
            foreach (r_bus[k]) seen.push_back(r_bus[k]);
            bus_enable = 1'b0;
            run(NS + 1);
            total += r_np;
            foreach (r_bus[k]) seen.push_back(r_bus[k]);
        end
        run(NS + 2);
        total += r_np;
        checks++;
        if (total !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d pulses, expected 2", total);
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 8'h3C || seen[1] !== 8'hC3) begin
            fails++;
            $display("FAIL b2b_data: got %0d captures first %h, expected 3c then c3",
                     seen.size(), (seen.size() > 0) ? seen[0] : 8'hxx);
        end
    endtask

    task automatic test_mid_reset();
        unsync_bus = 8'h5A;
        bus_enable = 1'b1;
        run(1);
        rst = 1'b0;
        run(NS + 2);
        checks++;
        if (r_np !== 0 || sync_bus !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset: got %0d pulses bus %h, expected 0 pulses bus 00", r_np, sync_bus);
        end
        rst = 1'b1;
        run(NS + 5);
        checks++;
        if (r_np !== 1 || r_first !== NS + 1 || sync_bus !== 8'h5A) begin
            fails++;
            $display("FAIL mid_reset_release: got %0d pulses first at %0d bus %h, expected 1 at %0d bus 5a",
                     r_np, r_first, sync_bus, NS + 1);
        end
        bus_enable = 1'b0;
        run(NS + 3);
    endtask
`else
    task automatic test_toggle();
        logic [BW-1:0] vals[2];
        vals[0] = 8'h77;
        vals[1] = 8'h88;
        for (int t = 0; t < 2; t++) begin
            unsync_bus = vals[t];
            bus_enable = ~bus_enable;
            run(5);
            checks++;
            if (r_np !== 1 || r_first !== NS + 1 || sync_bus !== vals[t]) begin
                fails++;
                $display("FAIL toggle_%0d: got %0d pulses first at %0d bus %h, expected 1 at %0d bus %h",
                         t, r_np, r_first, sync_bus, NS + 1, vals[t]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int hi;
        int lo;
        logic prev_pulse;
        prev_pulse = 1'b0;
        for (int t = 0; t < 40; t++) begin
            hi = ($urandom_range(0, 4) == 0) ? $urandom_range(1, NS) : $urandom_range(NS + 1, NS + 5);
            lo = ($urandom_range(0, 4) == 0) ? $urandom_range(1, NS) : $urandom_range(NS + 1, NS + 5);
            unsync_bus = BW'($urandom);
            bus_enable = 1'b1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) bus_enable = 1'b0;
                @(negedge clk);
                checks++;
                if (enable_pulse !== m_pulse || sync_bus !== m_bus) begin
                    fails++;
                    $display("FAIL random_t%0d_c%0d: got pulse %b bus %h, expected pulse %b bus %h",
                             t, c, enable_pulse, sync_bus, m_pulse, m_bus);
                end
`ifndef DATA_SYNC_TOGGLE_EN
                checks++;
                if (prev_pulse === 1'b1 && enable_pulse === 1'b1) begin
                    fails++;
                    $display("FAIL random_width_t%0d: got pulse high 2 cycles, expected 1", t);
                end
`endif
                prev_pulse = enable_pulse;
            end
        end
    endtask

    initial begin
        #1;
        @(negedge clk);
        test_reset();
`ifndef DATA_SYNC_TOGGLE_EN
        test_basic();
        test_data_hold();
        test_back_to_back();
        test_mid_reset();
`else
        test_toggle();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
